// File: rtl/noc_eject_port.sv
// Ejection end of a mesh node's local port: buffers incoming flits, filters by destination,
// presents payloads to the processor over valid/ready and returns credits to the router.
module noc_eject_port #(
   parameter logic [1:0]  NODE_ID = 2'd0,
   parameter int unsigned DEPTH   = 4,
   parameter int unsigned CNT_W   = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [10:0]      in_flit,
   input  logic             in_valid,
   output logic [1:0]       credit_out,
   output logic [6:0]       out_payload,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             processor_ready,
   output logic             misroute_err,
   output logic             overflow_err,
   output logic [CNT_W-1:0] rx_count
);

   localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned PW    = AW + 1;
   localparam int unsigned PAY_W = 7;

   localparam logic [1:0] CMD_DATA = 2'b01;

   localparam logic [0:0] ST_IDLE    = 1'b0;
   localparam logic [0:0] ST_PRESENT = 1'b1;

   logic [0:0]       state_q, state_d;
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [PAY_W-1:0] mem_q [DEPTH];
   logic [PAY_W-1:0] out_payload_q, out_payload_d;
   logic             out_valid_q, out_valid_d;
   logic [1:0]       credit_q, credit_d;
   logic             prdy_q, prdy_d;
   logic             mis_q, mis_d;
   logic             ovf_q, ovf_d;
   logic [CNT_W-1:0] rx_q, rx_d;

   logic [1:0]       cmd;
   logic [1:0]       dest;
   logic [PAY_W-1:0] payload;
   logic             fifo_empty;
   logic             fifo_full;
   logic             is_data;
   logic             dest_ok;
   logic             wr_en;
   logic             ovf_ev;
   logic             mis_ev;
   logic             handshake;
   logic             pop;

   // Ingress classification, FIFO control and presentation FSM.
   always_comb begin
      cmd        = in_flit[10:9];
      payload    = in_flit[8:2];
      dest       = in_flit[1:0];
      fifo_empty = (wr_ptr_q == rd_ptr_q);
      fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
      is_data    = in_valid && (cmd == CMD_DATA);
      dest_ok    = (dest == NODE_ID);
      wr_en      = is_data && dest_ok && !fifo_full;
      ovf_ev     = is_data && dest_ok && fifo_full;
      mis_ev     = in_valid && (cmd[1] || (is_data && !dest_ok));
      handshake  = out_valid_q && out_ready;

      state_d = state_q;
      pop     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (!fifo_empty) begin
               pop     = 1'b1;
               state_d = ST_PRESENT;
            end
         end
         default: begin
            if (out_ready) begin
               if (!fifo_empty) begin
                  pop = 1'b1;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
      endcase

      out_valid_d   = (state_d == ST_PRESENT);
      out_payload_d = pop ? mem_q[rd_ptr_q[AW-1:0]] : out_payload_q;
      wr_ptr_d      = wr_ptr_q + PW'(wr_en);
      rd_ptr_d      = rd_ptr_q + PW'(pop);
      // Pop frees a slot; a misrouted/reserved flit is consumed without a slot.
      credit_d      = 2'(pop) + 2'(mis_ev);
      rx_d          = rx_q + CNT_W'(handshake);
      prdy_d        = (state_q == ST_IDLE) && fifo_empty && !wr_en;
      mis_d         = mis_q | mis_ev;
      ovf_d         = ovf_q | ovf_ev;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q       <= ST_IDLE;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         out_payload_q <= '0;
         out_valid_q   <= 1'b0;
         credit_q      <= '0;
         prdy_q        <= 1'b1;
         mis_q         <= 1'b0;
         ovf_q         <= 1'b0;
         rx_q          <= '0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         state_q       <= state_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         out_payload_q <= out_payload_d;
         out_valid_q   <= out_valid_d;
         credit_q      <= credit_d;
         prdy_q        <= prdy_d;
         mis_q         <= mis_d;
         ovf_q         <= ovf_d;
         rx_q          <= rx_d;
         if (wr_en) begin
            mem_q[wr_ptr_q[AW-1:0]] <= payload;
         end
      end
   end

   assign credit_out      = credit_q;
   assign out_payload     = out_payload_q;
   assign out_valid       = out_valid_q;
   assign processor_ready = prdy_q;
   assign misroute_err    = mis_q;
   assign overflow_err    = ovf_q;
   assign rx_count        = rx_q;

endmodule
